// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring divider (signed/unsigned), one quotient bit
// per clock, with a start/busy/done handshake for stalling the EX stage.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   request, sampled only while busy=0
//   is_signed               1 = two's-complement operands (sampled with start)
//   dividend, divisor       operands (sampled with start)
//   busy                    high while an operation is in flight
//   done                    one-cycle pulse when results are valid
//   quotient, remainder     results, held until the next completion
//   div_by_zero             flag for the last completed op, held with results
//
// state  | meaning
// S_IDLE | waiting for start; results of last op held
// S_CALC | one shift-subtract iteration per edge, WIDTH edges total
// S_FIX  | apply signs (or divide-by-zero values), pulse done
module seq_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;       // {partial remainder, quotient}
  logic [WIDTH-1:0]   r_dvd_sh;    // abs(dividend), MSB feeds the remainder
  logic [WIDTH-1:0]   r_dvs_abs;
  logic [WIDTH-1:0]   r_dvd_orig;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_zero;

  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic [WIDTH-1:0]   w_dvd_abs;
  logic [WIDTH-1:0]   w_dvs_abs;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;

  assign w_dvd_neg = is_signed & dividend[WIDTH-1];
  assign w_dvs_neg = is_signed & divisor[WIDTH-1];
  // abs(MIN) wraps to MIN, which read as unsigned is exactly 2^(WIDTH-1).
  assign w_dvd_abs = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_abs = w_dvs_neg ? -divisor  : divisor;

  assign w_rem = r_acc[2*WIDTH-1:WIDTH];
  assign w_quo = r_acc[WIDTH-1:0];

  // Shifted remainder needs one extra bit: it can reach 2*divisor-1.
  assign w_shift   = {w_rem, r_dvd_sh[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dvs_abs});
  // When w_ge holds the true difference is below the divisor, so the low
  // WIDTH bits of the subtraction are exact.
  assign w_diff    = w_shift[WIDTH-1:0] - r_dvs_abs;
  assign w_rem_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {w_quo[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_dvd_sh    <= '0;
      r_dvs_abs   <= '0;
      r_dvd_orig  <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_zero      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd_sh   <= w_dvd_abs;
            r_dvs_abs  <= w_dvs_abs;
            r_dvd_orig <= dividend;
            r_neg_q    <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r    <= w_dvd_neg;
            r_acc      <= '0;
            busy       <= 1'b1;
            if (divisor == '0) begin
              r_zero  <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_FIX;
            end else begin
              r_zero  <= 1'b0;
              r_cnt   <= CW'(WIDTH);
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc    <= {w_rem_nxt, w_quo_nxt};
          r_dvd_sh <= r_dvd_sh << 1;
          r_cnt    <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_zero) begin
            quotient    <= '1;
            remainder   <= r_dvd_orig;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= r_neg_q ? -w_quo : w_quo;
            remainder   <= r_neg_r ? -w_rem : w_rem;
            div_by_zero <= 1'b0;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed-vector bench for seq_div (WIDTH=32 and WIDTH=8).
module tb_seq_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  logic        start8 = 1'b0;
  logic        sgn8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, done8, dbz8;
  logic [7:0]  q8, r8;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seq_div #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  seq_div #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sgn8),
    .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
    .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called mid-cycle; returns #1 after the accepting edge (edge N).
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after edge N until done is seen (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run(input string tag, input logic sgn, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                     input logic edz, input int elat);
    int cyc;
    launch(sgn, a, b);
    check({tag, " busy"}, 64'(busy), 64'(1));
    wait_done(cyc);
    check({tag, " latency"}, 64'(cyc), 64'(elat));
    check({tag, " quo"}, 64'(quotient), 64'(eq));
    check({tag, " rem"}, 64'(remainder), 64'(er));
    check({tag, " dbz"}, 64'(div_by_zero), 64'(edz));
    check({tag, " busy_low"}, 64'(busy), 64'(0));
  endtask

  task automatic run8(input string tag, input logic sgn, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] eq, input logic [7:0] er);
    int cyc;
    sgn8 = sgn;
    a8 = a;
    b8 = b;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(9));
    check({tag, " quo"}, 64'(q8), 64'(eq));
    check({tag, " rem"}, 64'(r8), 64'(er));
    check({tag, " dbz"}, 64'(dbz8), 64'(0));
  endtask

  initial begin
    int cyc;
    int n_done;

    #1;
    check("rst busy", 64'(busy), 64'(0));
    check("rst done", 64'(done), 64'(0));
    check("rst quo", 64'(quotient), 64'(0));
    check("rst rem", 64'(remainder), 64'(0));
    check("rst dbz", 64'(div_by_zero), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    @(posedge clk);
    #1;
    check("done_pulse_width", 64'(done), 64'(0));

    // The following ops each launch in the previous op's done cycle.
    run("s-100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
    run("s100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 33);
    // 4294967196 = 7 * 613566742 + 2
    run("u_big/7", 1'b0, 32'hFFFF_FF9C, 32'd7, 32'h2492_4916, 32'd2, 1'b0, 33);
    run("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
    run("dz_u", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1);
    run("dz_s", 1'b1, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1);
    run("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run("u7/9", 1'b0, 32'd7, 32'd9, 32'd0, 32'd7, 1'b0, 33);

    // Start pulses with different operands while busy must be ignored.
    @(posedge clk);
    #1;
    launch(1'b0, 32'd100, 32'd7);
    is_signed = 1'b1;
    dividend  = 32'd50;
    divisor   = 32'd5;
    start     = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc);
    check("ign latency", 64'(cyc + 5), 64'(33));
    check("ign quo", 64'(quotient), 64'(14));
    check("ign rem", 64'(remainder), 64'(2));
    n_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    check("ign no_queue", 64'(n_done), 64'(0));

    // Reset during iteration 10 aborts with no done.
    launch(1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'(0));
    check("midrst done", 64'(done), 64'(0));
    check("midrst quo", 64'(quotient), 64'(0));
    check("midrst rem", 64'(remainder), 64'(0));
    check("midrst dbz", 64'(div_by_zero), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    check("midrst no_done", 64'(n_done), 64'(0));
    run("post_rst", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);

    @(posedge clk);
    #1;
    run8("w8 255/16", 1'b0, 8'd255, 8'd16, 8'd15, 8'd15);
    run8("w8 -128/7", 1'b1, 8'h80, 8'd7, 8'hEE, 8'hFE);
    run8("w8 ovf", 1'b1, 8'h80, 8'hFF, 8'h80, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
